// File: rtl/pr_zoom_sequencer.sv
// 2x pixel-replication zoom sequencer: one read per source pixel, four writes to the destination.
// Optional build macro PR_PROGRESS_EN adds a 17-bit completed-write counter output `progress`.
module pr_zoom_sequencer #(
  parameter int unsigned SRC_W    = 160,
  parameter int unsigned SRC_H    = 120,
  parameter int unsigned SRC_BASE = 0,
  parameter int unsigned DST_BASE = 19200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        finished,
  output logic [16:0] mem_addr,
  output logic [2:0]  mem_op,
  output logic        mem_enable,
  input  logic        mem_done,
  input  logic [7:0]  rd_data,
  output logic [7:0]  wr_data
`ifdef PR_PROGRESS_EN
  ,
  output logic [16:0] progress
`endif
);

  localparam int unsigned XW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int unsigned YW = (SRC_H > 1) ? $clog2(SRC_H) : 1;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_RD   = 3'b001;
  localparam logic [2:0] OP_WR   = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_ADV,
    S_FINISH
  } state_t;

  state_t         state;
  logic [XW-1:0]  sx;
  logic [YW-1:0]  sy;
  logic [1:0]     q;

  logic [XW-1:0]  adv_sx;
  logic [YW-1:0]  adv_sy;
  logic           at_end_x;
  logic           at_end_y;
  logic [1:0]     q_next;

  // Constant multiply as a sum of shifted copies, one term per set bit of k.
  function automatic logic [16:0] mul_k(input logic [16:0] a, input int unsigned k);
    logic [16:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < 17; i++) begin
      if (((k >> i) & 32'd1) != 32'd0) acc = acc + (a << i);
    end
    return acc;
  endfunction

  function automatic logic [16:0] src_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return 17'(SRC_BASE) + mul_k(17'(y), SRC_W) + 17'(x);
  endfunction

  function automatic logic [16:0] dst_addr(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                          input logic [1:0] qq);
    return 17'(DST_BASE) + mul_k(17'({y, qq[1]}), 2 * SRC_W) + 17'({x, qq[0]});
  endfunction

  always_comb begin
    at_end_x = (sx == XW'(SRC_W - 1));
    at_end_y = (sy == YW'(SRC_H - 1));
    adv_sx   = at_end_x ? '0 : sx + 1'b1;
    adv_sy   = at_end_x ? sy + 1'b1 : sy;
    q_next   = q + 2'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      finished   <= 1'b0;
      mem_enable <= 1'b0;
      mem_op     <= OP_NONE;
      mem_addr   <= '0;
      wr_data    <= '0;
      sx         <= '0;
      sy         <= '0;
      q          <= '0;
`ifdef PR_PROGRESS_EN
      progress   <= '0;
`endif
    end else begin
      finished <= 1'b0;
      case (state)
        S_IDLE: begin
          mem_enable <= 1'b0;
          mem_op     <= OP_NONE;
          if (start) begin
            sx       <= '0;
            sy       <= '0;
            q        <= '0;
            mem_addr <= src_addr('0, '0);
            mem_op   <= OP_RD;
            busy     <= 1'b1;
            state    <= S_RD_REQ;
`ifdef PR_PROGRESS_EN
            progress <= '0;
`endif
          end
        end

        // Address and op are loaded on entry, so only enable moves inside REQ.
        S_RD_REQ, S_WR_REQ: begin
          if (!mem_enable) begin
            if (mem_done) mem_enable <= 1'b1;
          end else if (!mem_done) begin
            mem_enable <= 1'b0;
            mem_op     <= OP_NONE;
            state      <= (state == S_RD_REQ) ? S_RD_WAIT : S_WR_WAIT;
          end
        end

        S_RD_WAIT: begin
          if (mem_done) begin
            wr_data  <= rd_data;
            q        <= '0;
            mem_addr <= dst_addr(sx, sy, 2'd0);
            mem_op   <= OP_WR;
            state    <= S_WR_REQ;
          end
        end

        S_WR_WAIT: begin
          if (mem_done) begin
`ifdef PR_PROGRESS_EN
            progress <= progress + 17'd1;
`endif
            if (q != 2'd3) begin
              q        <= q_next;
              mem_addr <= dst_addr(sx, sy, q_next);
              mem_op   <= OP_WR;
              state    <= S_WR_REQ;
            end else begin
              state <= S_ADV;
            end
          end
        end

        S_ADV: begin
          if (at_end_x && at_end_y) begin
            finished <= 1'b1;
            state    <= S_FINISH;
          end else begin
            sx       <= adv_sx;
            sy       <= adv_sy;
            mem_addr <= src_addr(adv_sx, adv_sy);
            mem_op   <= OP_RD;
            state    <= S_RD_REQ;
          end
        end

        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          mem_enable <= 1'b0;
          mem_op     <= OP_NONE;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pr_zoom_sequencer.sv
// Scoreboard bench for pr_zoom_sequencer with a small image and a latency-randomised controller model.
// Expected request stream is generated from the zoom address rules by nested loops.
module tb_pr_zoom_sequencer;

  localparam int unsigned W  = 6;
  localparam int unsigned H  = 4;
  localparam int unsigned SB = 250;
  localparam int unsigned DB = 130000;

  typedef struct {
    logic [2:0]  op;
    int unsigned addr;
    logic [7:0]  data;
  } req_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        finished;
  logic [16:0] mem_addr;
  logic [2:0]  mem_op;
  logic        mem_enable;
  logic        mem_done;
  logic [7:0]  rd_data;
  logic [7:0]  wr_data;
`ifdef PR_PROGRESS_EN
  logic [16:0] progress;
`endif

  pr_zoom_sequencer #(
    .SRC_W(W),
    .SRC_H(H),
    .SRC_BASE(SB),
    .DST_BASE(DB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .busy(busy),
    .finished(finished),
    .mem_addr(mem_addr),
    .mem_op(mem_op),
    .mem_enable(mem_enable),
    .mem_done(mem_done),
    .rd_data(rd_data),
    .wr_data(wr_data)
`ifdef PR_PROGRESS_EN
    ,
    .progress(progress)
`endif
  );

  always #5 clock = ~clock;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  int unsigned n_ops = 0, n_rd = 0, n_wr = 0, fin_cnt = 0, fin_cyc = 0;
  int unsigned last_rd = 0, last_wr = 0;
  req_t        exp_q[$];
  req_t        e;

  task automatic chk(input string nm, input int unsigned got, input int unsigned exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Controller model: accepts when enable and done are both high, then stays busy.
  logic        ctl_idle  = 1'b1;
  int unsigned ctl_cnt   = 0;
  logic [7:0]  ctl_rd    = '0;
  logic        hold      = 1'b0;
  logic        rand_busy = 1'b0;

  assign mem_done = ctl_idle & ~hold;
  assign rd_data  = ctl_rd;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mem_enable && mem_done) begin
      ctl_idle <= 1'b0;
      ctl_cnt  <= rand_busy ? $urandom_range(4, 1) : 3;
      if (mem_op == 3'b001) ctl_rd <= mem_addr[7:0];
    end else if (!ctl_idle) begin
      if (ctl_cnt <= 1) ctl_idle <= 1'b1;
      else ctl_cnt <= ctl_cnt - 1;
    end
  end

  // Monitor: every request the controller is about to accept is checked against the queue.
  always @(negedge clock) begin
    if (finished) begin
      fin_cnt++;
      fin_cyc = cyc;
`ifdef PR_PROGRESS_EN
      chk("progress_final", 32'(progress), 4 * W * H);
`endif
    end
    if (mem_enable && mem_done) begin
      n_ops++;
      if (mem_op == 3'b001) begin
        n_rd++;
        last_rd = 32'(mem_addr);
      end else if (mem_op == 3'b010) begin
        n_wr++;
        last_wr = 32'(mem_addr);
      end
      if (exp_q.size() == 0) begin
        chk("unexpected_req", 32'(mem_addr), 0);
      end else begin
        e = exp_q.pop_front();
        chk("req_op", 32'(mem_op), 32'(e.op));
        chk("req_addr", 32'(mem_addr), e.addr);
        if (e.op == 3'b010) chk("wr_data", 32'(wr_data), 32'(e.data));
      end
`ifdef PR_PROGRESS_EN
      if (n_ops == 6) chk("progress_first_pixel", 32'(progress), 4);
`endif
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic load_model();
    int unsigned s;
    req_t r;
    exp_q.delete();
    n_ops = 0; n_rd = 0; n_wr = 0;
    for (int unsigned y = 0; y < H; y++) begin
      for (int unsigned x = 0; x < W; x++) begin
        s = SB + y * W + x;
        r.op = 3'b001; r.addr = s; r.data = '0;
        exp_q.push_back(r);
        for (int unsigned dy = 0; dy < 2; dy++) begin
          for (int unsigned dx = 0; dx < 2; dx++) begin
            r.op   = 3'b010;
            r.addr = DB + (2 * y + dy) * (2 * W) + 2 * x + dx;
            r.data = 8'(s);
            exp_q.push_back(r);
          end
        end
      end
    end
  endtask

  task automatic wait_fin(input string nm, input int unsigned f0);
    int unsigned n;
    n = 0;
    while (fin_cnt == f0 && n < 20000) begin
      step();
      n++;
    end
    if (fin_cnt == f0) chk(nm, fin_cnt, f0 + 1);
  endtask

  task automatic end_checks(input int unsigned f0);
    repeat (6) step();
    chk("finished_once", fin_cnt, f0 + 1);
    chk("queue_empty", 32'(exp_q.size()), 0);
    chk("read_count", n_rd, W * H);
    chk("write_count", n_wr, 4 * W * H);
    chk("last_read_addr", last_rd, SB + W * H - 1);
    chk("last_write_addr", last_wr, DB + 4 * W * H - 1);
    chk("busy_after_finish", 32'(busy), 0);
  endtask

  int unsigned f0, st_cyc, len_a, len_b, en_hi, n;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_finished", 32'(finished), 0);
    chk("rst_enable", 32'(mem_enable), 0);
    chk("rst_op", 32'(mem_op), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
`ifdef PR_PROGRESS_EN
    chk("rst_progress", 32'(progress), 0);
`endif
    reset = 1'b0;
    step();

    // Single start, fixed controller latency.
    load_model();
    f0 = fin_cnt;
    start = 1'b1; st_cyc = cyc;
    step();
    chk("busy_after_start", 32'(busy), 1);
    start = 1'b0;
    wait_fin("timeout_run_a", f0);
    len_a = fin_cyc - st_cyc;
    end_checks(f0);

    // start held high for the whole run must change nothing.
    load_model();
    f0 = fin_cnt;
    start = 1'b1; st_cyc = cyc;
    step();
    chk("busy_after_start_storm", 32'(busy), 1);
    wait_fin("timeout_run_b", f0);
    start = 1'b0;
    len_b = fin_cyc - st_cyc;
    chk("storm_finish_timing", len_b, len_a);
    end_checks(f0);

    // Controller busy before the first request; then random latencies.
    load_model();
    f0 = fin_cnt;
    hold = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    en_hi = 0;
    repeat (20) begin
      step();
      if (mem_enable) en_hi++;
    end
    chk("enable_while_done_low", en_hi, 0);
    chk("addr_while_waiting", 32'(mem_addr), SB);
    chk("op_while_waiting", 32'(mem_op), 1);
    hold = 1'b0;
    rand_busy = 1'b1;
    wait_fin("timeout_run_c", f0);
    end_checks(f0);

    // Reset while the 3rd write of pixel (5,0) is in flight.
    rand_busy = 1'b0;
    load_model();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (n_ops < 29 && n < 2000) begin
      step();
      n++;
    end
    if (n_ops < 29) chk("timeout_reach_pixel5", n_ops, 29);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_enable", 32'(mem_enable), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_op", 32'(mem_op), 0);
    chk("midrst_addr", 32'(mem_addr), 0);
`ifdef PR_PROGRESS_EN
    chk("midrst_progress", 32'(progress), 0);
`endif
    load_model();
    f0 = fin_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    en_hi = 0;
    n = 0;
    while (!mem_done && n < 100) begin
      if (mem_enable) en_hi++;
      step();
      n++;
    end
    chk("restart_enable_while_busy", en_hi, 0);
    rand_busy = 1'b1;
    wait_fin("timeout_run_d", f0);
    end_checks(f0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
